// File: rtl/store_align_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : store_align_unit_if
// Description : Signal bundle for store_align_unit. Carries the pipeline
//               store handshake (st_*), the data-bus write request (dreq_*),
//               the bus response (dresp_*) and the completion/status flags.
//               Modports:
//                 slave  - the store_align_unit itself
//                 master - the surrounding pipeline/bus environment
// Revision    : 1.0 - initial release
// ============================================================================
interface store_align_unit_if;

    // pipeline store request
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [2:0]  st_msize;

    // data-bus write request
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;

    // data-bus response
    logic        dresp_addr_ok;
    logic        dresp_data_ok;

    // completion / status back to the pipeline
    logic        done;
    logic        bus_err;
    logic        busy;

    modport slave (
        input  st_valid, st_addr, st_data, st_msize,
        input  dresp_addr_ok, dresp_data_ok,
        output st_ready,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output done, bus_err, busy
    );

    modport master (
        output st_valid, st_addr, st_data, st_msize,
        output dresp_addr_ok, dresp_data_ok,
        input  st_ready,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  done, bus_err, busy
    );

endinterface : store_align_unit_if
`default_nettype wire

// File: rtl/store_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_align_unit
// Description : Store-side aligner of the memory stage. Accepts one store per
//               handshake, replicates the register data into the addressed
//               byte lanes, builds the 8-bit write strobe and runs a single
//               data-bus write transaction, reporting done or bus_err.
// Ports       : clk     - clock, rising edge
//               resetn  - asynchronous active-low reset
//               sau     - store_align_unit_if.slave (st_*, dreq_*, dresp_*,
//                         done, bus_err, busy)
// Parameters  : TIMEOUT_CYCLES - cycles allowed in REQ+WAIT (0 = no timeout)
//               CNT_W          - timeout counter width, 2^CNT_W > TIMEOUT_CYCLES
// Options     : STORE_MISALIGN_CHECK_EN - when defined, misaligned halfword,
//               word and doubleword stores are rejected with bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
module store_align_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    store_align_unit_if.slave  sau
);

    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               c_timeout_en = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // captured request (what the bus sees)
    logic [63:0]      r_addr;
    logic [2:0]       r_size;
    logic [7:0]       r_strobe;
    logic [63:0]      r_data;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    logic             r_done;
    logic             r_bus_err;
    logic             w_done_nxt;
    logic             w_err_nxt;

    logic [63:0]      w_lane_data;
    logic [7:0]       w_lane_strobe;
    logic             w_illegal;
    logic             w_reject;
    logic             w_accept;

    // ------------------------------------------------------------------------
    // Lane build from the incoming request. The result is registered at
    // accept, so the bus only ever sees flopped values. Address bits finer
    // than the access size do not take part in lane selection.
    // ------------------------------------------------------------------------
    always_comb begin
        w_lane_data   = '0;
        w_lane_strobe = '0;
        w_illegal     = 1'b0;
        case (sau.st_msize)
            3'd0: begin
                w_lane_data   = {8{sau.st_data[7:0]}};
                w_lane_strobe = 8'b0000_0001 << sau.st_addr[2:0];
            end
            3'd1: begin
                w_lane_data   = {4{sau.st_data[15:0]}};
                w_lane_strobe = 8'b0000_0011 << {sau.st_addr[2:1], 1'b0};
            end
            3'd2: begin
                w_lane_data   = {2{sau.st_data[31:0]}};
                w_lane_strobe = 8'b0000_1111 << {sau.st_addr[2], 2'b00};
            end
            3'd3: begin
                w_lane_data   = sau.st_data;
                w_lane_strobe = 8'hFF;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef STORE_MISALIGN_CHECK_EN
    logic w_misalign;

    always_comb begin
        w_misalign = 1'b0;
        case (sau.st_msize)
            3'd1:    w_misalign = sau.st_addr[0];
            3'd2:    w_misalign = |sau.st_addr[1:0];
            3'd3:    w_misalign = |sau.st_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_reject = w_illegal | w_misalign;
`else
    assign w_reject = w_illegal;
`endif

    assign w_accept  = sau.st_valid && (r_state == S_IDLE);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Fires in the cycle that completes the TIMEOUT_CYCLES-th REQ/WAIT cycle.
    assign w_timeout = c_timeout_en && (w_cnt_inc == c_timeout);

    // ------------------------------------------------------------------------
    // Next-state and pulse decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // data_ok alone implies the address was taken as well.
                // A completion in the final allowed cycle wins over timeout.
                if (sau.dresp_data_ok) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (sau.dresp_addr_ok) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sau.dresp_data_ok) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_bus_err <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Request capture. Rejected stores are not captured so the bus lines keep
    // their previous values while no request is issued.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_strobe <= '0;
            r_data   <= '0;
        end else if (w_accept && !w_reject) begin
            r_addr   <= sau.st_addr;
            r_size   <= sau.st_msize;
            r_strobe <= w_lane_strobe;
            r_data   <= w_lane_data;
        end
    end

    // ------------------------------------------------------------------------
    // Timeout counter: cleared on accept, counts every REQ/WAIT cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. dreq_valid decodes straight from the state register, so the
    // asynchronous reset drops it immediately.
    // ------------------------------------------------------------------------
    assign sau.st_ready    = (r_state == S_IDLE);
    assign sau.dreq_valid  = (r_state == S_REQ);
    assign sau.dreq_addr   = r_addr;
    assign sau.dreq_size   = r_size;
    assign sau.dreq_strobe = r_strobe;
    assign sau.dreq_data   = r_data;
    assign sau.done        = r_done;
    assign sau.bus_err     = r_bus_err;
    assign sau.busy        = (r_state != S_IDLE);

endmodule : store_align_unit
`default_nettype wire

// File: tb/tb_store_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_align_unit
// Description : Self-checking bench for store_align_unit. Expected bus
//               requests and outcomes are queued when a store is driven and
//               compared when the DUT issues the request / reports status.
//               A second instance with TIMEOUT_CYCLES=4 covers the timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_align_unit;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } req_t;

    logic clk;
    logic resetn;

    int   n_tests = 0;
    int   n_fail  = 0;

    req_t req_q[$];
    logic out_q[$];   // 1 = done expected, 0 = bus_err expected
    logic req_seen;

    store_align_unit_if sif ();
    store_align_unit_if tif ();

    store_align_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .sau    (sif)
    );

    store_align_unit #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut_to (
        .clk    (clk),
        .resetn (resetn),
        .sau    (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [63:0] a, input logic [63:0] d, input logic [2:0] sz);
        int n;
        n = 0;
        sif.st_valid = 1'b1;
        sif.st_addr  = a;
        sif.st_data  = d;
        sif.st_msize = sz;
        while (!sif.st_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", sif.st_ready, 1'b1);
        @(posedge clk); #1;
        sif.st_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        req_t e;
        logic o;
        if (!resetn) begin
            req_seen = 1'b0;
        end else begin
            if (sif.dreq_valid && !req_seen) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", sif.dreq_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = req_q.pop_front();
                    check("req_addr",   sif.dreq_addr,   e.addr);
                    check("req_size",   sif.dreq_size,   e.size);
                    check("req_strobe", sif.dreq_strobe, e.strobe);
                    check("req_data",   sif.dreq_data,   e.data);
                end
            end
            req_seen = sif.dreq_valid;
            if (sif.done || sif.bus_err) begin
                check("done_err_excl", sif.done & sif.bus_err, 1'b0);
                if (out_q.size() == 0) begin
                    check("unexpected_out", {sif.done, sif.bus_err}, 2'b00);
                end else begin
                    o = out_q.pop_front();
                    check("outcome_done", sif.done, o);
                end
            end
        end
    end

    initial begin
        req_seen          = 1'b0;
        sif.st_valid      = 1'b0;
        sif.st_addr       = '0;
        sif.st_data       = '0;
        sif.st_msize      = '0;
        sif.dresp_addr_ok = 1'b0;
        sif.dresp_data_ok = 1'b0;
        tif.st_valid      = 1'b0;
        tif.st_addr       = '0;
        tif.st_data       = '0;
        tif.st_msize      = '0;
        tif.dresp_addr_ok = 1'b0;
        tif.dresp_data_ok = 1'b0;
        resetn            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_st_ready",   sif.st_ready,    1'b1);
        check("rst_busy",       sif.busy,        1'b0);
        check("rst_dreq_valid", sif.dreq_valid,  1'b0);
        check("rst_strobe",     sif.dreq_strobe, 8'h00);
        check("rst_data",       sif.dreq_data,   64'h0);
        check("rst_done",       sif.done,        1'b0);
        check("rst_bus_err",    sif.bus_err,     1'b0);
        resetn = 1'b1;
        tick();

        // SB, same-cycle addr_ok+data_ok
        req_q.push_back('{64'h1003, 3'd0, 8'h08, 64'hABAB_ABAB_ABAB_ABAB});
        out_q.push_back(1'b1);
        send(64'h1003, 64'hAB, 3'd0);
        check("sb_dreq_valid", sif.dreq_valid, 1'b1);
        sif.dresp_addr_ok = 1'b1;
        sif.dresp_data_ok = 1'b1;
        tick();
        sif.dresp_addr_ok = 1'b0;
        sif.dresp_data_ok = 1'b0;
        check("sb_done",  sif.done,     1'b1);
        check("sb_ready", sif.st_ready, 1'b1);
        tick();

        // SH, addr_ok in cycle 1, data_ok three cycles later
        req_q.push_back('{64'h2006, 3'd1, 8'hC0, 64'h1234_1234_1234_1234});
        out_q.push_back(1'b1);
        send(64'h2006, 64'h1234, 3'd1);
        sif.dresp_addr_ok = 1'b1;
        tick();
        sif.dresp_addr_ok = 1'b0;
        check("sh_wait_valid", sif.dreq_valid,  1'b0);
        check("sh_wait_busy",  sif.busy,        1'b1);
        check("sh_wait_strb",  sif.dreq_strobe, 8'hC0);
        tick();
        check("sh_no_early_done", sif.done, 1'b0);
        tick();
        sif.dresp_data_ok = 1'b1;
        tick();
        sif.dresp_data_ok = 1'b0;
        check("sh_done", sif.done, 1'b1);
        tick();
        check("sh_done_once", sif.done, 1'b0);

        // SW then SD back-to-back on a zero-wait bus
        req_q.push_back('{64'h8004, 3'd2, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF});
        out_q.push_back(1'b1);
        req_q.push_back('{64'h8000, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF});
        out_q.push_back(1'b1);
        sif.dresp_addr_ok = 1'b1;
        sif.dresp_data_ok = 1'b1;
        sif.st_valid      = 1'b1;
        sif.st_addr       = 64'h8004;
        sif.st_data       = 64'hDEAD_BEEF;
        sif.st_msize      = 3'd2;
        check("b2b_ready0", sif.st_ready, 1'b1);
        tick();
        sif.st_addr  = 64'h8000;
        sif.st_data  = 64'h0123_4567_89AB_CDEF;
        sif.st_msize = 3'd3;
        check("b2b_req_sw", sif.dreq_strobe, 8'hF0);
        tick();
        check("b2b_done_sw",  sif.done,     1'b1);
        check("b2b_ready_sw", sif.st_ready, 1'b1);
        tick();
        sif.st_valid = 1'b0;
        check("b2b_req_sd", sif.dreq_strobe, 8'hFF);
        tick();
        check("b2b_done_sd", sif.done, 1'b1);
        sif.dresp_addr_ok = 1'b0;
        sif.dresp_data_ok = 1'b0;
        tick();

        // illegal msize
        out_q.push_back(1'b0);
        send(64'h3000, 64'h55, 3'd5);
        check("ill_bus_err",    sif.bus_err,    1'b1);
        check("ill_dreq_valid", sif.dreq_valid, 1'b0);
        check("ill_ready",      sif.st_ready,   1'b1);
        tick();

        // SW at 0x8002: rejected with the misalign check, otherwise issued
`ifdef STORE_MISALIGN_CHECK_EN
        out_q.push_back(1'b0);
`else
        req_q.push_back('{64'h8002, 3'd2, 8'h0F, 64'h1122_3344_1122_3344});
        out_q.push_back(1'b1);
`endif
        sif.dresp_addr_ok = 1'b1;
        sif.dresp_data_ok = 1'b1;
        send(64'h8002, 64'h1122_3344, 3'd2);
        tick();
        sif.dresp_addr_ok = 1'b0;
        sif.dresp_data_ok = 1'b0;
        tick();

        // timeout on the TIMEOUT_CYCLES=4 instance
        tif.st_valid = 1'b1;
        tif.st_addr  = 64'h40;
        tif.st_data  = 64'h77;
        tif.st_msize = 3'd0;
        check("to_ready", tif.st_ready, 1'b1);
        tick();
        tif.st_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_req_valid", tif.dreq_valid, 1'b1);
            check("to_no_err",    tif.bus_err,    1'b0);
            tick();
        end
        check("to_bus_err", tif.bus_err,    1'b1);
        check("to_no_done", tif.done,       1'b0);
        check("to_busy",    tif.busy,       1'b0);
        check("to_valid",   tif.dreq_valid, 1'b0);
        tick();
        tif.dresp_data_ok = 1'b1;
        tick();
        tif.dresp_data_ok = 1'b0;
        check("to_stray_done", tif.done,    1'b0);
        check("to_stray_err",  tif.bus_err, 1'b0);
        check("to_stray_busy", tif.busy,    1'b0);

        // reset asserted during WAIT
        req_q.push_back('{64'h10, 3'd0, 8'h01, 64'h9999_9999_9999_9999});
        send(64'h10, 64'h99, 3'd0);
        sif.dresp_addr_ok = 1'b1;
        tick();
        sif.dresp_addr_ok = 1'b0;
        check("rw_busy_before", sif.busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("rw_busy",   sif.busy,        1'b0);
        check("rw_valid",  sif.dreq_valid,  1'b0);
        check("rw_strobe", sif.dreq_strobe, 8'h00);
        check("rw_ready",  sif.st_ready,    1'b1);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // new SB after reset release, zero-wait bus
        req_q.push_back('{64'h7, 3'd0, 8'h80, 64'h5A5A_5A5A_5A5A_5A5A});
        out_q.push_back(1'b1);
        send(64'h7, 64'h5A, 3'd0);
        sif.dresp_addr_ok = 1'b1;
        sif.dresp_data_ok = 1'b1;
        tick();
        sif.dresp_addr_ok = 1'b0;
        sif.dresp_data_ok = 1'b0;
        check("post_rst_done", sif.done, 1'b1);
        tick();
        tick();

        check("req_q_empty", 64'(req_q.size()), 64'd0);
        check("out_q_empty", 64'(out_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_store_align_unit
`default_nettype wire
